// File: rtl/dlx_fetch_pkg.sv
// dlx_fetch_pkg: shared types and constants for the DLX instruction fetch stage.
package dlx_fetch_pkg;
   typedef enum logic [1:0] {BOOT, REQ, HOLD, DRAIN} fetch_state_e;
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_STEP           = 32'd4;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry holding register for a word fetched while IF/ID is stalled.
module fetch_skid_buffer (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        unload,
   input  logic        flush,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_plus_four_in,
   output logic [31:0] instr,
   output logic [31:0] pc_plus_four,
   output logic        full
);
   logic [31:0] instr_q, instr_d, ppf_q, ppf_d;
   logic        full_q, full_d;
   always_comb begin
      instr_d = load ? instr_in : instr_q;
      ppf_d   = load ? pc_plus_four_in : ppf_q;
      full_d  = load | (full_q & ~(unload | flush));
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q <= '0;
         ppf_q   <= '0;
         full_q  <= 1'b0;
      end else begin
         instr_q <= instr_d;
         ppf_q   <= ppf_d;
         full_q  <= full_d;
      end
   end
   assign instr        = instr_q;
   assign pc_plus_four = ppf_q;
   assign full         = full_q;
endmodule

// File: rtl/instr_fetch_redirect.sv
// instr_fetch_redirect: DLX IF stage - PC, imem req/ack fetch, IF/ID register, branch redirect.
module instr_fetch_redirect
   import dlx_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        take_branch,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc_plus_four,
   output logic        ifid_valid
);
   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d, tgt_q, tgt_d, instr_q, instr_d, ppf_q, ppf_d;
   logic         valid_q, valid_d;
   logic         buf_load, buf_unload, buf_flush, buf_full;
   logic [31:0]  buf_instr, buf_ppf;
   logic         redirect, ack;
   logic [31:0]  pc_inc, target;

   assign redirect = take_branch & ~stall;
   assign target   = branch_target & ~32'h3;
   assign pc_inc   = pc_q + PC_STEP;
   assign imem_req = (state_q == REQ) | (state_q == DRAIN);
   assign ack      = imem_req & imem_ack;

   fetch_skid_buffer u_skid (
      .clk             (clk),
      .reset           (reset),
      .load            (buf_load),
      .unload          (buf_unload),
      .flush           (buf_flush),
      .instr_in        (imem_rdata),
      .pc_plus_four_in (pc_inc),
      .instr           (buf_instr),
      .pc_plus_four    (buf_ppf),
      .full            (buf_full)
   );

   // An unstalled IF/ID defaults to a bubble; only a real delivery overrides it.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      tgt_d      = tgt_q;
      instr_d    = stall ? instr_q : NOP_INSTR;
      ppf_d      = stall ? ppf_q : '0;
      valid_d    = valid_q & stall;
      buf_load   = 1'b0;
      buf_unload = 1'b0;
      buf_flush  = 1'b0;
      case (state_q)
         BOOT: state_d = REQ;
         REQ: begin
            if (redirect) begin
               if (ack) pc_d = target;
               else begin
                  tgt_d   = target;
                  state_d = DRAIN;
               end
            end else if (ack) begin
               pc_d = pc_inc;
               if (stall) begin
                  buf_load = 1'b1;
                  state_d  = HOLD;
               end else begin
                  instr_d = imem_rdata;
                  ppf_d   = pc_inc;
                  valid_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               buf_flush = 1'b1;
               pc_d      = target;
               state_d   = REQ;
            end else if (!stall) begin
               buf_unload = 1'b1;
               instr_d    = buf_instr;
               ppf_d      = buf_ppf;
               valid_d    = buf_full;
               state_d    = REQ;
            end
         end
         DRAIN: begin
            // The request in flight cannot be aborted; its data is thrown away on ack.
            if (redirect) tgt_d = target;
            if (ack) begin
               pc_d    = redirect ? target : tgt_q;
               state_d = REQ;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         tgt_q   <= RESET_PC;
         instr_q <= NOP_INSTR;
         ppf_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         instr_q <= instr_d;
         ppf_q   <= ppf_d;
         valid_q <= valid_d;
      end
   end

   assign imem_addr         = pc_q;
   assign ifid_instr        = instr_q;
   assign ifid_pc_plus_four = ppf_q;
   assign ifid_valid        = valid_q;
endmodule

// File: tb/tb_instr_fetch_redirect.sv
// tb_instr_fetch_redirect: directed stimulus with a queue scoreboard for acked fetch addresses and IF/ID deliveries.
module tb_instr_fetch_redirect;
   logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, take_branch = 1'b0, imem_ack = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] imem_rdata, imem_addr, ifid_instr, ifid_pc_plus_four;
   logic        imem_req, ifid_valid;
   logic        prev_upd = 1'b0;
   int          checks = 0, failures = 0;
   logic [31:0] exp_addr[$];
   logic [63:0] exp_ifid[$];

   always #5 clk = ~clk;
   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

   instr_fetch_redirect dut (
      .clk               (clk),
      .reset             (reset),
      .stall             (stall),
      .take_branch       (take_branch),
      .branch_target     (branch_target),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ack          (imem_ack),
      .imem_rdata        (imem_rdata),
      .ifid_instr        (ifid_instr),
      .ifid_pc_plus_four (ifid_pc_plus_four),
      .ifid_valid        (ifid_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic st, input logic tb, input logic [31:0] tgt, input logic ack);
      stall = st;
      take_branch = tb;
      branch_target = tgt;
      imem_ack = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic ack);
      step(1'b0, 1'b0, 32'h0, ack);
   endtask

   task automatic br(input logic [31:0] tgt, input logic ack);
      step(1'b0, 1'b1, tgt, ack);
   endtask

   task automatic push_fetch(input logic [31:0] a, input logic [31:0] ppf);
      exp_addr.push_back(a);
      exp_ifid.push_back({a ^ 32'hA5A5_0000, ppf});
   endtask

   task automatic push_drop(input logic [31:0] a);
      exp_addr.push_back(a);
   endtask

   task automatic fetch_run(input logic [31:0] a, input int n);
      for (int i = 0; i < n; i++) begin
         push_fetch(a + 32'(4 * i), a + 32'(4 * i + 4));
         go(1'b1);
      end
   endtask

   // Monitor: a handshake happens where req&ack are high; an IF/ID delivery is a valid slot loaded by an unstalled edge.
   always @(negedge clk) begin
      if (reset) prev_upd <= 1'b0;
      else begin
         if (imem_req && imem_ack) begin
            if (exp_addr.size() == 0) chk("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
            else begin
               chk("fetch_addr", imem_addr, exp_addr[0]);
               void'(exp_addr.pop_front());
            end
         end
         if (prev_upd && ifid_valid) begin
            if (exp_ifid.size() == 0) chk("unexpected_ifid", ifid_instr, 32'hFFFF_FFFF);
            else begin
               chk("ifid_instr", ifid_instr, exp_ifid[0][63:32]);
               chk("ifid_ppf", ifid_pc_plus_four, exp_ifid[0][31:0]);
               void'(exp_ifid.pop_front());
            end
         end
         prev_upd <= !stall;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      imem_ack = 1'b1;
      #12;
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(ifid_valid), 32'h0);
      chk("rst_instr", ifid_instr, 32'h0);
      chk("rst_ppf", ifid_pc_plus_four, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("boot_req", 32'(imem_req), 32'h0);
      go(1'b1);
      chk("first_req", 32'(imem_req), 32'h1);
      chk("first_addr", imem_addr, 32'h0);
      push_fetch(32'h00, 32'h04);
      push_fetch(32'h04, 32'h08);
      push_fetch(32'h08, 32'h0C);
      push_fetch(32'h0C, 32'h10);
      repeat (4) go(1'b1);
      push_fetch(32'h10, 32'h14);
      for (int i = 0; i < 3; i++) begin
         chk("delay_addr", imem_addr, 32'h10);
         go(1'b0);
         chk("delay_bubble", 32'(ifid_valid), 32'h0);
      end
      chk("delay_addr", imem_addr, 32'h10);
      go(1'b1);
      fetch_run(32'h14, 3);
      chk("stall_addr", imem_addr, 32'h20);
      push_fetch(32'h20, 32'h24);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 32'h0, 1'b1);
         chk("hold_req", 32'(imem_req), 32'h0);
         chk("hold_instr", ifid_instr, 32'hA5A5_001C);
         chk("hold_valid", 32'(ifid_valid), 32'h1);
      end
      go(1'b1);
      chk("after_hold_addr", imem_addr, 32'h24);
      fetch_run(32'h24, 7);
      chk("br_ack_addr", imem_addr, 32'h40);
      push_drop(32'h40);
      br(32'h100, 1'b1);
      chk("br_ack_valid", 32'(ifid_valid), 32'h0);
      chk("br_ack_next", imem_addr, 32'h100);
      push_fetch(32'h100, 32'h104);
      go(1'b1);
      push_drop(32'h104);
      br(32'h103, 1'b1);
      chk("br_align_valid", 32'(ifid_valid), 32'h0);
      chk("br_align_addr", imem_addr, 32'h100);
      push_fetch(32'h100, 32'h104);
      go(1'b1);
      push_drop(32'h104);
      br(32'h50, 1'b1);
      chk("drain_start_addr", imem_addr, 32'h50);
      br(32'h200, 1'b0);
      chk("drain_req", 32'(imem_req), 32'h1);
      chk("drain_addr1", imem_addr, 32'h50);
      chk("drain_valid1", 32'(ifid_valid), 32'h0);
      br(32'h300, 1'b0);
      chk("drain_addr2", imem_addr, 32'h50);
      chk("drain_valid2", 32'(ifid_valid), 32'h0);
      push_drop(32'h50);
      go(1'b1);
      chk("drain_next", imem_addr, 32'h300);
      chk("drain_exit_valid", 32'(ifid_valid), 32'h0);
      push_fetch(32'h300, 32'h304);
      go(1'b1);
      push_drop(32'h304);
      br(32'hFFFF_FFF8, 1'b1);
      push_fetch(32'hFFFF_FFF8, 32'hFFFF_FFFC);
      push_fetch(32'hFFFF_FFFC, 32'h0);
      go(1'b1);
      go(1'b1);
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_ppf", ifid_pc_plus_four, 32'h0);
      push_fetch(32'h0, 32'h4);
      go(1'b1);
      br(32'h400, 1'b0);
      chk("pre_rst_req", 32'(imem_req), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_req", 32'(imem_req), 32'h0);
      chk("mid_rst_valid", 32'(ifid_valid), 32'h0);
      chk("mid_rst_addr", imem_addr, 32'h0);
      stall = 1'b0;
      take_branch = 1'b0;
      imem_ack = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reboot_req", 32'(imem_req), 32'h0);
      go(1'b1);
      chk("refetch_addr", imem_addr, 32'h0);
      push_fetch(32'h0, 32'h4);
      push_fetch(32'h4, 32'h8);
      go(1'b1);
      go(1'b1);
      repeat (3) go(1'b0);
      chk("addr_queue_empty", 32'(exp_addr.size()), 32'h0);
      chk("ifid_queue_empty", 32'(exp_ifid.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/instr_fetch_redirect.md
Name: instr_fetch_redirect

Overview:
- IF stage of the DLX pipeline. Owns the PC, issues instruction-memory requests over a req/ack handshake, and loads the IF/ID register.
- It is the consumer end of the decode-stage branch resolution interface: accepts take_branch/branch_target and squashes the wrong-path fetch. There is no delay slot.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0000, value loaded into ifid_instr whenever the slot is squashed or invalid

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard unit: hold IF/ID contents this cycle
take_branch  in  1  decode-stage branch unit: redirect fetch; honoured only when stall=0
branch_target  in  32  redirect PC; bits [1:0] ignored (forced to 00)
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address; stable while imem_req=1 and not yet acked
imem_ack  in  1  read data valid this cycle; only meaningful when imem_req=1
imem_rdata  in  32  fetched instruction word
ifid_instr  out  32  IF/ID instruction
ifid_pc_plus_four  out  32  IF/ID PC+4 of ifid_instr (feeds branch adder / jal link)
ifid_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, immediate): state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus_four=0, ifid_valid=0. Reset discards any outstanding imem transaction.
- imem_addr is always the pc register. pc+4 wraps modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0.
- States:
  - BOOT: imem_req=0 for one cycle, then REQ.
  - REQ: imem_req=1.
  - HOLD: word fetched while stalled; it sits in the skid buffer; imem_req=0.
  - DRAIN: redirect arrived while a request was outstanding; imem_req stays 1 at the old address until ack, because a request cannot be aborted.
- REQ, ack, stall=0, no take_branch: IF/ID <= {rdata, pc+4, valid=1}; pc <= pc+4; remain in REQ. This gives back-to-back fetch, 1 instr/cycle with a single-cycle ack.
- REQ, ack, stall=1: word and pc+4 go into the buffer; pc <= pc+4; go to HOLD; IF/ID unchanged.
- REQ, no ack: wait. IF/ID holds if stall=1. If stall=0, it loads NOP_INSTR with valid=0 (bubble).
- HOLD, stall=1: hold everything.
- HOLD, stall=0, no take_branch: IF/ID <= buffer (valid=1); go to REQ.
- take_branch=1 with stall=0 (a redirect):
  - IF/ID <= {NOP_INSTR, 0, valid=0}.
  - In REQ with ack this cycle: rdata discarded; pc <= target; stay REQ. The new address is presented next cycle.
  - In REQ without ack: latch target; go to DRAIN.
  - In HOLD: discard buffer; pc <= target; go to REQ.
  - In DRAIN: overwrite the latched target (last redirect wins).
- DRAIN, ack: discard rdata; pc <= latched target; go to REQ. IF/ID stays invalid while in DRAIN.
- Redirect penalty: 1 bubble with single-cycle imem, more while draining.
- take_branch while stall=1 is ignored; the hazard unit reasserts it when the stall clears.
- imem_ack while imem_req=0 is ignored.

Decomposition:
- Package dlx_fetch_pkg holds:
  - the state enum {BOOT, REQ, HOLD, DRAIN};
  - the RESET_PC and NOP_INSTR defaults;
  - the PC_STEP=4 constant.
- One sub-module, fetch_skid_buffer: a one-entry {instr, pc_plus_four, full} register with load/unload/flush.
- The FSM, PC register and IF/ID register stay in the top.

Test Plan:
- Reset release, imem acks every cycle with rdata=addr^32'hA5A5_0000 -> imem_req first rises the cycle after BOOT; ifid shows 0x00, 0x04, 0x08 with pc_plus_four 4, 8, 12 and valid=1 each cycle.
- Ack delayed 3 cycles at addr 0x10 -> imem_addr held at 0x10 for all 4 req cycles; 3 bubbles (valid=0); then instr loaded with pc_plus_four=0x14.
- stall=1 for 2 cycles while ack arrives for 0x20 -> HOLD, imem_req=0, IF/ID frozen; after stall drops the 0x20 word appears with pc_plus_four=0x24.
- take_branch=1, target=0x100 coincident with ack of 0x40 -> 0x40 word dropped, ifid_valid=0 next cycle, next imem_addr=0x100. Also target=0x103 -> fetch at 0x100.
- take_branch (target 0x200) then second take_branch (target 0x300) while 0x50 request unacked -> DRAIN; after ack, next imem_addr=0x300; 0x50 word never reaches IF/ID.
- pc at 0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000; ifid_pc_plus_four=0. Reset asserted mid-DRAIN -> imem_req=0 and ifid_valid=0 immediately; fetch restarts at RESET_PC.
